// File: rtl/seg7_ctrl.sv
// seg7_ctrl: bus-side latch for a 32-bit word, shown as eight hex digits on a
// common-anode seven-segment display by time-multiplexing the anodes.
module seg7_ctrl #(
    parameter int SCAN_BITS = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        seg7_we,
    input  logic [31:0] cpuseg7_data,
    input  logic        lz_blank,
    output logic [31:0] disp_data_o,
    output logic [7:0]  disp_an_o,
    output logic [7:0]  disp_seg_o
);

    localparam int CNT_W = SCAN_BITS + 3;

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_data;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic [2:0]       w_dig;
    logic [3:0]       w_nib;
    logic [2:0]       w_msd;
    logic             w_blank;
    logic [7:0]       w_seg;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is never lit.
    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Digit index is the top three counter bits, so each digit dwells 2^SCAN_BITS cycles.
    assign w_dig = r_cnt[CNT_W-1 -: 3];
    assign w_nib = r_data[w_dig*4 +: 4];

    // Position of the most significant nonzero nibble (0 for an all-zero word).
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_data[i*4 +: 4] != 4'h0) w_msd = 3'(i);
        end
    end

    assign w_blank = lz_blank && (w_dig > w_msd);
    assign w_seg   = w_blank ? 8'hFF : hex2seg(w_nib);

    // Free-running scan counter, wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_cnt <= '0;
        else       r_cnt <= r_cnt + 1'b1;
    end

    // Display word: captured on a bus write, otherwise held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_data <= '0;
        else if (seg7_we) r_data <= cpuseg7_data;
    end

    // Registered drives use the pre-edge counter and data, so a write and a
    // digit change landing on the same edge appear together one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(8'd1 << w_dig);
            r_seg <= w_seg;
        end
    end

    assign disp_data_o = r_data;
    assign disp_an_o   = r_an;
    assign disp_seg_o  = r_seg;

endmodule

// File: tb/tb_seg7_ctrl.sv
// Directed bench for seg7_ctrl with SCAN_BITS=2 (4 cycles per digit, 32 per frame).
module tb_seg7_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        seg7_we;
    logic [31:0] cpuseg7_data;
    logic        lz_blank;
    logic [31:0] disp_data_o;
    logic [7:0]  disp_an_o;
    logic [7:0]  disp_seg_o;

    int n_cmp = 0;
    int n_err = 0;

    seg7_ctrl #(.SCAN_BITS(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .seg7_we      (seg7_we),
        .cpuseg7_data (cpuseg7_data),
        .lz_blank     (lz_blank),
        .disp_data_o  (disp_data_o),
        .disp_an_o    (disp_an_o),
        .disp_seg_o   (disp_seg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle write, driven and sampled on falling edges.
    task automatic bus_write(input logic [31:0] d);
        seg7_we      = 1'b1;
        cpuseg7_data = d;
        @(negedge clk);
        seg7_we      = 1'b0;
        chk("write", disp_data_o, d);
    endtask

    // Land on the first cycle of digit 0 (anode 7F followed by FE), bounded.
    task automatic sync_frame();
        logic [7:0] prev;
        bit         found;
        found = 1'b0;
        prev  = disp_an_o;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (prev == 8'h7F && disp_an_o == 8'hFE) found = 1'b1;
            else prev = disp_an_o;
        end
        chk("sync", 32'(found), 32'd1);
    endtask

    // Check a whole frame; segs holds digit d's expected pattern in [d*8 +: 8].
    task automatic chk_frame(input string tag, input logic [63:0] segs);
        logic [7:0] an_exp;
        for (int i = 0; i < 32; i++) begin
            an_exp = ~(8'd1 << (i / 4));
            chk({tag, "_an"}, 32'(disp_an_o), 32'(an_exp));
            chk({tag, "_seg"}, 32'(disp_seg_o), 32'(segs[(i/4)*8 +: 8]));
            if (i < 31) @(negedge clk);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        seg7_we      = 1'b0;
        cpuseg7_data = 32'h0;
        lz_blank     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(disp_an_o), 32'hFF);
        chk("rst_seg", 32'(disp_seg_o), 32'hFF);
        chk("rst_data", disp_data_o, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("first_an", 32'(disp_an_o), 32'hFE);
        chk("first_seg", 32'(disp_seg_o), 32'hC0);

        // Full scan of 0x12345678 (digit 7 .. digit 0 in the vector)
        bus_write(32'h12345678);
        sync_frame();
        chk_frame("scan", 64'hF9_A4_B0_99_92_82_F8_80);

        // Leading-zero blanking
        bus_write(32'h000000A0);
        lz_blank = 1'b1;
        sync_frame();
        chk_frame("lz1", 64'hFF_FF_FF_FF_FF_FF_88_C0);
        lz_blank = 1'b0;
        sync_frame();
        chk_frame("lz0", 64'hC0_C0_C0_C0_C0_C0_88_C0);
        lz_blank = 1'b1;
        bus_write(32'h00000000);
        sync_frame();
        chk_frame("lz_zero", 64'hFF_FF_FF_FF_FF_FF_FF_C0);
        lz_blank = 1'b0;

        // Write gating: data without strobe is ignored
        cpuseg7_data = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        chk("gate_hold", disp_data_o, 32'h0);
        bus_write(32'hDEADBEEF);
        sync_frame();
        chk_frame("dead", 64'hA1_86_88_A1_83_86_86_8E);

        // Boundary write: strobe on the edge where the counter goes 15 -> 16
        sync_frame();
        repeat (14) @(negedge clk);
        seg7_we      = 1'b1;
        cpuseg7_data = 32'hFFFFFFFF;
        @(negedge clk);
        seg7_we      = 1'b0;
        chk("bnd_last3_an", 32'(disp_an_o), 32'hF7);
        chk("bnd_last3_seg", 32'(disp_seg_o), 32'h83);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("bnd_d4_an", 32'(disp_an_o), 32'hEF);
            chk("bnd_d4_seg", 32'(disp_seg_o), 32'h8E);
        end

        // Asynchronous reset during digit 5
        sync_frame();
        repeat (21) @(negedge clk);
        chk("mid_d5_an", 32'(disp_an_o), 32'hDF);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_an", 32'(disp_an_o), 32'hFF);
        chk("mid_rst_seg", 32'(disp_seg_o), 32'hFF);
        chk("mid_rst_data", disp_data_o, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("restart_an", 32'(disp_an_o), (k <= 4) ? 32'hFE : 32'hFD);
            chk("restart_seg", 32'(disp_seg_o), 32'hC0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
